motion_detect_pipe: RTL and testbench
=====================================

Name: motion_detect_pipe

Overview:
- Pipelined, frame-aware successor to the combinational motion comparator.
- Per pixel: converts previous-frame and current-frame RGB565 pixels to 8-bit intensity (luma or green-only, runtime-selectable) and takes the absolute difference.
- Flags motion against a per-frame-latched threshold and accumulates flagged pixels over a frame.
- Sits between frame-buffer readout and VGA overlay/alarm logic; emits one per-frame report (count plus area-exceeded flag).

Parameters:
- CNT_W, 17, width of the per-frame motion-pixel counter (covers 320x240 = 76800).
- DEF_THRESH, 8'd10, pixel threshold used when threshold input is 0.
- DEF_AREA, 17'd512, area threshold used when area_thresh input is 0.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- mode, input, 1, 0 = green-channel compare, 1 = luma compare; latched at frame_start.
- threshold, input, 8, pixel difference threshold; latched at frame_start.
- area_thresh, input, CNT_W, motion-pixel count threshold; latched at frame_start.
- frame_start, input, 1, pulse coincident with first pixel of a frame.
- frame_end, input, 1, pulse coincident with last pixel of a frame.
- pixel_valid, input, 1, prev_data/curr_data valid this cycle.
- prev_data, input, 16, RGB565 pixel, previous frame.
- curr_data, input, 16, RGB565 pixel, current frame.
- motion_flag, output, 1, per-pixel motion result.
- motion_valid, output, 1, qualifies motion_flag.
- motion_count, output, CNT_W, flagged pixels in last completed frame.
- frame_motion, output, 1, motion_count > latched area threshold.
- report_valid, output, 1, one-cycle pulse when motion_count/frame_motion update.
- busy, output, 1, high in ACCUM or FLUSH.

Behaviour:
- Reset (async, any time, including mid-frame):
  - All outputs 0; state IDLE; pipeline valids cleared; counter 0.
  - Latched config = DEF_THRESH, DEF_AREA, mode 0.
- Expansion: R8 = {R5,3'b0}; G8 = {G6,2'b0}; B8 = {B5,3'b0}.
- Mode 1: Y = (77*R8 + 150*G8 + 29*B8) >> 8, computed in 16-bit unsigned, upper byte taken.
- Mode 0: Y = G8.
- Pipeline: S1 registers Y_prev, Y_curr; S2 registers diff = |Y_curr - Y_prev| (8-bit, no wrap); S3 registers motion_flag = (diff > thr), strictly greater.
- Latency: motion_valid/motion_flag appear exactly 3 cycles after the pixel_valid cycle. Valid propagates with a bubble wherever pixel_valid = 0. No backpressure.
- Config latch: mode, threshold and area_thresh are captured on the frame_start cycle; a 0 input selects the DEF_* value. They are held for the whole frame. The first pixel uses the newly latched values.
- FSM:
  - IDLE: on frame_start & pixel_valid -> ACCUM. Counter cleared; latch config.
  - ACCUM: count S3 flags whose pixel was tagged in-frame. On frame_end & pixel_valid -> FLUSH, tagging that pixel as last.
  - FLUSH: continue counting until the tagged last pixel exits S3 -> REPORT.
  - REPORT: one cycle. Register motion_count and frame_motion; pulse report_valid; -> IDLE.
  - report_valid is therefore exactly 4 cycles after the frame_end cycle.
- Frame tagging: pixels accepted outside ACCUM (or outside the first cycle) still produce motion_flag but are never counted.
- Boundaries:
  - frame_start & frame_end in the same cycle: single-pixel frame; straight to FLUSH.
  - frame_start while ACCUM/FLUSH: abort current frame (no report), clear counter, relatch config, restart ACCUM. In-flight pixels of the old frame are dropped from the count.
  - frame_end while IDLE: ignored.
  - frame_start/frame_end without pixel_valid: ignored.
  - Counter saturates at 2^CNT_W - 1, no wrap.
  - motion_count/frame_motion hold between reports.

Decomposition:
- Shared package motion_pkg:
  - typedef enum mode_e {MODE_GREEN, MODE_LUMA}.
  - FSM state enum {IDLE, ACCUM, FLUSH, REPORT}.
  - Localparams LUMA_KR = 77, LUMA_KG = 150, LUMA_KB = 29, PIPE_LAT = 3.
- One sub-module rgb565_to_y: combinational RGB565 -> 8-bit intensity with mode select. Instantiated twice ahead of the S1 registers.

Test Plan:
- Luma max diff: mode = 1, threshold = 10, prev = 16'h0000, curr = 16'hFFFF, one pixel -> Y 0 vs 250, motion_flag = 1, motion_valid 3 cycles later.
- Strict threshold: mode = 0, threshold = 8, prev = 0, curr G6 = 2 (G8 = 8) -> flag = 0; curr G6 = 3 (12) -> flag = 1.
- Frame report: 100-pixel frame with 40 motion pixels, area_thresh = 30 -> report_valid 4 cycles after frame_end, motion_count = 40, frame_motion = 1; rerun with area_thresh = 40 -> frame_motion = 0.
- Defaults/latching: threshold = 0 -> 10 used; change threshold to 200 mid-frame -> no effect until next frame_start.
- Abort: frame_start during ACCUM after 20 motion pixels, then 5-pixel frame with 5 motion pixels -> single report, motion_count = 5.
- Reset mid-FLUSH: assert reset 2 cycles after frame_end -> all outputs 0 immediately, no report_valid, busy = 0.

Source files
------------

// File: rtl/motion_detect_pipe_pkg.sv
// -----------------------------------------------------------------------------
// motion_pkg
// Shared types and constants for the pipelined motion detector.
//   mode_e   : intensity source select (green channel or luma)
//   state_e  : frame-accumulation FSM states
//   LUMA_K*  : 8-bit luma weights (sum = 256, so >>8 gives an 8-bit result)
//   PIPE_LAT : pixel-to-flag latency in cycles
//   abs_diff8: absolute difference of two unsigned bytes, no wrap
// -----------------------------------------------------------------------------
package motion_pkg;

   typedef enum logic {
      MODE_GREEN = 1'b0,
      MODE_LUMA  = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      FLUSH  = 2'd2,
      REPORT = 2'd3
   } state_e;

   localparam logic [7:0] LUMA_KR  = 8'd77;
   localparam logic [7:0] LUMA_KG  = 8'd150;
   localparam logic [7:0] LUMA_KB  = 8'd29;
   localparam int         PIPE_LAT = 3;

   function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] d;
      if (a > b) begin
         d = a - b;
      end else begin
         d = b - a;
      end
      return d;
   endfunction

endpackage

// File: rtl/motion_detect_pipe_rgb565_to_y.sv
// -----------------------------------------------------------------------------
// rgb565_to_y
// Combinational RGB565 -> 8-bit intensity.
//   mode : MODE_GREEN -> expanded green channel, MODE_LUMA -> weighted luma
//   rgb  : RGB565 pixel {R5, G6, B5}
//   y    : 8-bit intensity
// -----------------------------------------------------------------------------
module rgb565_to_y
   import motion_pkg::*;
(
   input  mode_e       mode,
   input  logic [15:0] rgb,
   output logic [7:0]  y
);

   logic [7:0]  r8;
   logic [7:0]  g8;
   logic [7:0]  b8;
   logic [15:0] luma_sum;

   // Channel expansion zero-fills the low bits rather than replicating MSBs.
   assign r8 = {rgb[15:11], 3'b000};
   assign g8 = {rgb[10:5], 2'b00};
   assign b8 = {rgb[4:0], 3'b000};

   // Worst case 77*248 + 150*252 + 29*248 = 64088, so 16 bits never overflow.
   assign luma_sum = ({8'd0, LUMA_KR} * {8'd0, r8})
                   + ({8'd0, LUMA_KG} * {8'd0, g8})
                   + ({8'd0, LUMA_KB} * {8'd0, b8});

   // Select intensity source; luma keeps the upper byte of the weighted sum.
   always_comb begin
      y = g8;
      if (mode == MODE_LUMA) begin
         y = 8'(luma_sum >> 4'd8);
      end else begin
         y = g8;
      end
   end

endmodule

// File: rtl/motion_detect_pipe.sv
// -----------------------------------------------------------------------------
// motion_detect_pipe
// Three-stage per-pixel motion comparator with per-frame accumulation.
//   clk, reset      : clock, asynchronous active-high reset
//   mode            : 0 green compare, 1 luma compare (latched at frame start)
//   threshold       : pixel diff threshold, 0 selects DEF_THRESH (latched)
//   area_thresh     : motion-pixel count threshold, 0 selects DEF_AREA (latched)
//   frame_start/end : frame delimiters, only honoured together with pixel_valid
//   pixel_valid     : prev_data/curr_data valid
//   prev_data       : RGB565 pixel of the previous frame
//   curr_data       : RGB565 pixel of the current frame
//   motion_flag     : per-pixel result, qualified by motion_valid (3 cycles)
//   motion_count    : flagged pixels in last completed frame
//   frame_motion    : motion_count > latched area threshold
//   report_valid    : one-cycle pulse when the report registers update
//   busy            : FSM in ACCUM or FLUSH
// -----------------------------------------------------------------------------
module motion_detect_pipe
   import motion_pkg::*;
#(
   parameter int               CNT_W      = 17,
   parameter logic [7:0]       DEF_THRESH = 8'd10,
   parameter logic [CNT_W-1:0] DEF_AREA   = 17'd512
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             mode,
   input  logic [7:0]       threshold,
   input  logic [CNT_W-1:0] area_thresh,
   input  logic             frame_start,
   input  logic             frame_end,
   input  logic             pixel_valid,
   input  logic [15:0]      prev_data,
   input  logic [15:0]      curr_data,
   output logic             motion_flag,
   output logic             motion_valid,
   output logic [CNT_W-1:0] motion_count,
   output logic             frame_motion,
   output logic             report_valid,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   state_e               state_r;
   state_e               state_next;
   mode_e                mode_r;
   mode_e                mode_use_s;
   logic [7:0]           thr_r;
   logic [CNT_W-1:0]     area_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [CNT_W-1:0]     cnt_next_s;
   logic                 frame_go_s;
   logic                 in_frame_s;
   logic                 last_s;
   logic                 count_hit_s;
   logic                 flush_done_s;
   logic [7:0]           y_prev_s;
   logic [7:0]           y_curr_s;
   logic [7:0]           y_prev_r;
   logic [7:0]           y_curr_r;
   logic [7:0]           diff_r;
   // Sideband per pipeline stage: [0]=S1, [1]=S2, [PIPE_LAT-1]=S3.
   logic [PIPE_LAT-1:0]  v_pipe_r;
   logic [PIPE_LAT-1:0]  tag_pipe_r;
   logic [PIPE_LAT-1:0]  last_pipe_r;

   assign frame_go_s = frame_start & pixel_valid;
   // A starting pixel always belongs to the new frame, whatever the state.
   assign in_frame_s = frame_go_s | (pixel_valid & (state_r == ACCUM));
   assign last_s     = in_frame_s & frame_end;

   // The first pixel of a frame must see the new mode, not the stale latch.
   assign mode_use_s = frame_go_s ? mode_e'(mode) : mode_r;

   rgb565_to_y u_y_prev (
      .mode (mode_use_s),
      .rgb  (prev_data),
      .y    (y_prev_s)
   );

   rgb565_to_y u_y_curr (
      .mode (mode_use_s),
      .rgb  (curr_data),
      .y    (y_curr_s)
   );

   assign count_hit_s  = v_pipe_r[PIPE_LAT-1] & tag_pipe_r[PIPE_LAT-1] & motion_flag;
   assign cnt_next_s   = (count_hit_s && (cnt_r != CNT_MAX)) ? (cnt_r + CNT_ONE) : cnt_r;
   assign flush_done_s = (state_r == FLUSH) & v_pipe_r[PIPE_LAT-1] & last_pipe_r[PIPE_LAT-1];
   assign motion_valid = v_pipe_r[PIPE_LAT-1];

   // Per-frame configuration latch; zero inputs fall back to the defaults.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_r <= MODE_GREEN;
         thr_r  <= DEF_THRESH;
         area_r <= DEF_AREA;
      end else if (frame_go_s) begin
         mode_r <= mode_e'(mode);
         thr_r  <= (threshold == 8'd0) ? DEF_THRESH : threshold;
         area_r <= (area_thresh == CNT_ZERO) ? DEF_AREA : area_thresh;
      end else begin
         mode_r <= mode_r;
         thr_r  <= thr_r;
         area_r <= area_r;
      end
   end

   // Data pipeline: S1 intensities, S2 absolute difference, S3 strict compare.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_prev_r    <= 8'd0;
         y_curr_r    <= 8'd0;
         diff_r      <= 8'd0;
         motion_flag <= 1'b0;
      end else begin
         y_prev_r    <= y_prev_s;
         y_curr_r    <= y_curr_s;
         diff_r      <= abs_diff8(y_curr_r, y_prev_r);
         motion_flag <= v_pipe_r[1] & (diff_r > thr_r);
      end
   end

   // Valid/tag/last sideband; a new frame drops the tags of in-flight pixels.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_pipe_r    <= {PIPE_LAT{1'b0}};
         tag_pipe_r  <= {PIPE_LAT{1'b0}};
         last_pipe_r <= {PIPE_LAT{1'b0}};
      end else if (frame_go_s) begin
         v_pipe_r    <= {v_pipe_r[PIPE_LAT-2:0], pixel_valid};
         tag_pipe_r  <= {{(PIPE_LAT-1){1'b0}}, in_frame_s};
         last_pipe_r <= {{(PIPE_LAT-1){1'b0}}, last_s};
      end else begin
         v_pipe_r    <= {v_pipe_r[PIPE_LAT-2:0], pixel_valid};
         tag_pipe_r  <= {tag_pipe_r[PIPE_LAT-2:0], in_frame_s};
         last_pipe_r <= {last_pipe_r[PIPE_LAT-2:0], last_s};
      end
   end

   // Next-state logic; a valid frame_start restarts from any state.
   always_comb begin
      state_next = state_r;
      if (frame_go_s) begin
         if (frame_end) begin
            state_next = FLUSH;
         end else begin
            state_next = ACCUM;
         end
      end else begin
         case (state_r)
            IDLE: begin
               state_next = IDLE;
            end
            ACCUM: begin
               if (pixel_valid && frame_end) begin
                  state_next = FLUSH;
               end else begin
                  state_next = ACCUM;
               end
            end
            FLUSH: begin
               if (flush_done_s) begin
                  state_next = REPORT;
               end else begin
                  state_next = FLUSH;
               end
            end
            REPORT: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State register and registered busy indication.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         busy    <= 1'b0;
      end else begin
         state_r <= state_next;
         busy    <= (state_next == ACCUM) || (state_next == FLUSH);
      end
   end

   // Saturating motion-pixel counter for the frame in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= CNT_ZERO;
      end else if (frame_go_s) begin
         cnt_r <= CNT_ZERO;
      end else if ((state_r == ACCUM) || (state_r == FLUSH)) begin
         cnt_r <= cnt_next_s;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Report registers load on entry to REPORT so they are visible during it;
   // the last pixel's own hit is folded in through cnt_next_s.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         report_valid <= 1'b0;
         motion_count <= CNT_ZERO;
         frame_motion <= 1'b0;
      end else if ((state_r == FLUSH) && (state_next == REPORT)) begin
         report_valid <= 1'b1;
         motion_count <= cnt_next_s;
         frame_motion <= (cnt_next_s > area_r);
      end else begin
         report_valid <= 1'b0;
         motion_count <= motion_count;
         frame_motion <= frame_motion;
      end
   end

endmodule

// File: tb/tb_motion_detect_pipe.sv
// -----------------------------------------------------------------------------
// tb_motion_detect_pipe
// Directed, self-checking bench for motion_detect_pipe. Inputs change 1 ns
// after each rising edge; outputs are sampled there or on the falling edge.
// -----------------------------------------------------------------------------
module tb_motion_detect_pipe;

   localparam int CNT_W = 17;

   logic             clk = 1'b0;
   logic             reset;
   logic             mode;
   logic [7:0]       threshold;
   logic [CNT_W-1:0] area_thresh;
   logic             frame_start;
   logic             frame_end;
   logic             pixel_valid;
   logic [15:0]      prev_data;
   logic [15:0]      curr_data;
   logic             motion_flag;
   logic             motion_valid;
   logic [CNT_W-1:0] motion_count;
   logic             frame_motion;
   logic             report_valid;
   logic             busy;

   int total = 0;
   int bad   = 0;

   logic             flags_q[$];
   int               rep_seen = 0;
   logic [CNT_W-1:0] rep_cnt  = '0;
   logic             rep_fm   = 1'b0;

   motion_detect_pipe #(
      .CNT_W      (CNT_W),
      .DEF_THRESH (8'd10),
      .DEF_AREA   (17'd512)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mode         (mode),
      .threshold    (threshold),
      .area_thresh  (area_thresh),
      .frame_start  (frame_start),
      .frame_end    (frame_end),
      .pixel_valid  (pixel_valid),
      .prev_data    (prev_data),
      .curr_data    (curr_data),
      .motion_flag  (motion_flag),
      .motion_valid (motion_valid),
      .motion_count (motion_count),
      .frame_motion (frame_motion),
      .report_valid (report_valid),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Record every qualified flag and every report seen on the falling edge.
   always @(negedge clk) begin
      if (motion_valid) flags_q.push_back(motion_flag);
      if (report_valid) begin
         rep_seen <= rep_seen + 1;
         rep_cnt  <= motion_count;
         rep_fm   <= frame_motion;
      end
   end

   task automatic px(input logic fs, input logic fe, input logic pv,
                     input logic [15:0] p, input logic [15:0] c);
      frame_start = fs;
      frame_end   = fe;
      pixel_valid = pv;
      prev_data   = p;
      curr_data   = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) px(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mode = 1'b0; threshold = 8'd0; area_thresh = 17'd0;
      frame_start = 1'b0; frame_end = 1'b0; pixel_valid = 1'b0;
      prev_data = 16'h0000; curr_data = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      total++; if (motion_flag !== 1'b0) begin bad++; $display("FAIL reset_flag got=%0b exp=0", motion_flag); end
      total++; if (motion_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", motion_valid); end
      total++; if (motion_count !== 17'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", motion_count); end
      total++; if (frame_motion !== 1'b0) begin bad++; $display("FAIL reset_frame_motion got=%0b exp=0", frame_motion); end
      total++; if (report_valid !== 1'b0) begin bad++; $display("FAIL reset_report got=%0b exp=0", report_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
      reset = 1'b0;
      idle(2);
   endtask

   // Single-pixel luma frame: Y 0 vs 250, flag exactly 3 cycles later.
   task automatic test_luma_max();
      mode = 1'b1; threshold = 8'd10; area_thresh = 17'd0;
      px(1'b1, 1'b1, 1'b1, 16'h0000, 16'hFFFF);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL luma_busy got=%0b exp=1", busy); end
      idle(1);
      total++; if (motion_valid !== 1'b0) begin bad++; $display("FAIL luma_early_valid got=%0b exp=0", motion_valid); end
      idle(1);
      total++; if (motion_valid !== 1'b1) begin bad++; $display("FAIL luma_valid got=%0b exp=1", motion_valid); end
      total++; if (motion_flag !== 1'b1) begin bad++; $display("FAIL luma_flag got=%0b exp=1", motion_flag); end
      total++; if (report_valid !== 1'b0) begin bad++; $display("FAIL luma_early_report got=%0b exp=0", report_valid); end
      idle(1);
      total++; if (report_valid !== 1'b1) begin bad++; $display("FAIL luma_report got=%0b exp=1", report_valid); end
      total++; if (motion_count !== 17'd1) begin bad++; $display("FAIL luma_count got=%0d exp=1", motion_count); end
      total++; if (frame_motion !== 1'b0) begin bad++; $display("FAIL luma_frame_motion got=%0b exp=0", frame_motion); end
      idle(1);
      total++; if (report_valid !== 1'b0) begin bad++; $display("FAIL luma_report_pulse got=%0b exp=0", report_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL luma_busy_after got=%0b exp=0", busy); end
   endtask

   // Green mode, threshold 8: diff 8 is not motion, diff 12 is.
   task automatic test_strict_thresh();
      int r0;
      mode = 1'b0; threshold = 8'd8; area_thresh = 17'd0;
      flags_q.delete();
      r0 = rep_seen;
      px(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0040);
      px(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0060);
      idle(6);
      total++; if (flags_q.size() !== 2) begin bad++; $display("FAIL strict_nflags got=%0d exp=2", flags_q.size()); end
      total++; if (flags_q[0] !== 1'b0) begin bad++; $display("FAIL strict_eq got=%0b exp=0", flags_q[0]); end
      total++; if (flags_q[1] !== 1'b1) begin bad++; $display("FAIL strict_gt got=%0b exp=1", flags_q[1]); end
      total++; if (rep_seen - r0 !== 1) begin bad++; $display("FAIL strict_nreports got=%0d exp=1", rep_seen - r0); end
      total++; if (rep_cnt !== 17'd1) begin bad++; $display("FAIL strict_count got=%0d exp=1", rep_cnt); end
   endtask

   // 100-pixel frame, 40 motion pixels; area 30 then area 40.
   task automatic test_frame_report();
      logic        mot;
      logic [15:0] p;
      logic [15:0] c;
      int          ones;
      mode = 1'b0; threshold = 8'd0;
      for (int run = 0; run < 2; run++) begin
         area_thresh = (run == 0) ? 17'd30 : 17'd40;
         flags_q.delete();
         for (int i = 0; i < 100; i++) begin
            mot = ((i % 5) < 2);
            p = mot ? 16'h0000 : 16'h1234;
            c = mot ? 16'h07E0 : 16'h1234;
            px((i == 0), (i == 99), 1'b1, p, c);
         end
         idle(2);
         total++; if (report_valid !== 1'b0) begin bad++; $display("FAIL frame_early_report run=%0d got=%0b exp=0", run, report_valid); end
         total++; if (motion_count !== ((run == 0) ? 17'd1 : 17'd40)) begin bad++; $display("FAIL frame_hold run=%0d got=%0d exp=%0d", run, motion_count, (run == 0) ? 1 : 40); end
         idle(1);
         total++; if (report_valid !== 1'b1) begin bad++; $display("FAIL frame_report run=%0d got=%0b exp=1", run, report_valid); end
         total++; if (motion_count !== 17'd40) begin bad++; $display("FAIL frame_count run=%0d got=%0d exp=40", run, motion_count); end
         total++; if (frame_motion !== ((run == 0) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL frame_area run=%0d got=%0b exp=%0b", run, frame_motion, (run == 0)); end
         idle(2);
         ones = 0;
         foreach (flags_q[k]) if (flags_q[k]) ones++;
         total++; if (ones !== 40) begin bad++; $display("FAIL frame_flags run=%0d got=%0d exp=40", run, ones); end
      end
   endtask

   // Threshold 0 means 10; a mid-frame change waits for the next frame.
   task automatic test_defaults_latching();
      mode = 1'b0; threshold = 8'd0; area_thresh = 17'd0;
      flags_q.delete();
      px(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0040);
      threshold = 8'd200;
      px(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0060);
      px(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0060);
      idle(6);
      total++; if (flags_q.size() !== 3) begin bad++; $display("FAIL deflt_nflags got=%0d exp=3", flags_q.size()); end
      total++; if (flags_q[0] !== 1'b0) begin bad++; $display("FAIL deflt_diff8 got=%0b exp=0", flags_q[0]); end
      total++; if (flags_q[1] !== 1'b1) begin bad++; $display("FAIL deflt_midframe got=%0b exp=1", flags_q[1]); end
      total++; if (rep_cnt !== 17'd2) begin bad++; $display("FAIL deflt_count got=%0d exp=2", rep_cnt); end
      flags_q.delete();
      px(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0620);
      px(1'b0, 1'b1, 1'b1, 16'h0000, 16'h07E0);
      idle(6);
      total++; if (flags_q.size() !== 2) begin bad++; $display("FAIL latch_nflags got=%0d exp=2", flags_q.size()); end
      total++; if (flags_q[0] !== 1'b0) begin bad++; $display("FAIL latch_diff196 got=%0b exp=0", flags_q[0]); end
      total++; if (flags_q[1] !== 1'b1) begin bad++; $display("FAIL latch_diff252 got=%0b exp=1", flags_q[1]); end
      total++; if (rep_cnt !== 17'd1) begin bad++; $display("FAIL latch_count got=%0d exp=1", rep_cnt); end
      threshold = 8'd10;
   endtask

   // Restart after 20 motion pixels, then a 5-pixel frame: one report of 5.
   task automatic test_abort();
      int r0;
      mode = 1'b0; threshold = 8'd10; area_thresh = 17'd3;
      r0 = rep_seen;
      for (int i = 0; i < 20; i++) px((i == 0), 1'b0, 1'b1, 16'h0000, 16'h07E0);
      for (int i = 0; i < 5; i++) px((i == 0), (i == 4), 1'b1, 16'h0000, 16'h07E0);
      idle(8);
      total++; if (rep_seen - r0 !== 1) begin bad++; $display("FAIL abort_nreports got=%0d exp=1", rep_seen - r0); end
      total++; if (rep_cnt !== 17'd5) begin bad++; $display("FAIL abort_count got=%0d exp=5", rep_cnt); end
      total++; if (rep_fm !== 1'b1) begin bad++; $display("FAIL abort_area got=%0b exp=1", rep_fm); end
   endtask

   // frame_end in IDLE and frame_start without pixel_valid do nothing.
   task automatic test_ignored();
      int r0;
      r0 = rep_seen;
      flags_q.delete();
      px(1'b0, 1'b1, 1'b1, 16'h0000, 16'h07E0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_end_busy got=%0b exp=0", busy); end
      px(1'b1, 1'b0, 1'b0, 16'h0000, 16'h07E0);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_start_busy got=%0b exp=0", busy); end
      idle(6);
      total++; if (rep_seen - r0 !== 0) begin bad++; $display("FAIL ign_nreports got=%0d exp=0", rep_seen - r0); end
      total++; if (flags_q.size() !== 1) begin bad++; $display("FAIL ign_nflags got=%0d exp=1", flags_q.size()); end
      total++; if (flags_q[0] !== 1'b1) begin bad++; $display("FAIL ign_flag got=%0b exp=1", flags_q[0]); end
   endtask

   // Reset asserted two cycles after frame_end, while FLUSH is draining.
   task automatic test_reset_flush();
      int r0;
      mode = 1'b0; threshold = 8'd10; area_thresh = 17'd0;
      for (int i = 0; i < 3; i++) px((i == 0), (i == 2), 1'b1, 16'h0000, 16'h07E0);
      idle(1);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstf_busy_before got=%0b exp=1", busy); end
      #2;
      reset = 1'b1;
      #1;
      total++; if (motion_count !== 17'd0) begin bad++; $display("FAIL rstf_count got=%0d exp=0", motion_count); end
      total++; if (frame_motion !== 1'b0) begin bad++; $display("FAIL rstf_frame_motion got=%0b exp=0", frame_motion); end
      total++; if (motion_valid !== 1'b0) begin bad++; $display("FAIL rstf_valid got=%0b exp=0", motion_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstf_busy got=%0b exp=0", busy); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      r0 = rep_seen;
      idle(8);
      total++; if (rep_seen - r0 !== 0) begin bad++; $display("FAIL rstf_nreports got=%0d exp=0", rep_seen - r0); end
      total++; if (motion_count !== 17'd0) begin bad++; $display("FAIL rstf_count_after got=%0d exp=0", motion_count); end
   endtask

   initial begin
      test_reset();
      test_luma_max();
      test_strict_thresh();
      test_frame_report();
      test_defaults_latching();
      test_abort();
      test_ignored();
      test_reset_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
